// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: EXE request/response, multiplier and divider handshakes
// for the mul/div sequencing controller. The controller takes the slave side.
interface muldiv_ctrl_if;
    // EXE request side
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        cancel;
    logic        res_ack;
    // EXE response / architectural state
    logic        done;
    logic        busy;
    logic [31:0] res_lo;
    logic [31:0] res_hi;
    logic [31:0] hi;
    logic [31:0] lo;
    // pipelined multiplier
    logic        mul_start;
    logic        mul_signed;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_prod;
    // handshaked divider
    logic        div_tvalid;
    logic        div_tready;
    logic        div_signed;
    logic        div_dout_tvalid;
    logic [31:0] div_quot;
    logic [31:0] div_rem;

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, cancel, res_ack,
        input  mul_prod, div_tready, div_dout_tvalid, div_quot, div_rem,
        output done, busy, res_lo, res_hi, hi, lo,
        output mul_start, mul_signed, mul_a, mul_b, div_tvalid, div_signed
    );

    modport master (
        output req_valid, req_op, req_src1, req_src2, cancel, res_ack,
        output mul_prod, div_tready, div_dout_tvalid, div_quot, div_rem,
        input  done, busy, res_lo, res_hi, hi, lo,
        input  mul_start, mul_signed, mul_a, mul_b, div_tvalid, div_signed
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: EXE-stage mul/div sequencer owning the architectural HI/LO pair.
// Drives a fixed-latency multiplier (MUL_LAT cycles) and a handshaked divider,
// holds the result pending until EXE advances, and drains a cancelled divide.
// Optional macro MULDIV_ACC_EN enables MADD/MADDU/MSUB/MSUBU accumulate ops.
module muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_MUL_WAIT, S_DIV_ISSUE, S_DIV_WAIT, S_DONE, S_DRAIN
    } state_t;

    localparam logic [3:0] OP_MULT  = 4'h0;
    localparam logic [3:0] OP_MULTU = 4'h1;
    localparam logic [3:0] OP_DIV   = 4'h2;
    localparam logic [3:0] OP_DIVU  = 4'h3;
    localparam logic [3:0] OP_MTHI  = 4'h4;
    localparam logic [3:0] OP_MTLO  = 4'h5;
    localparam logic [3:0] OP_MUL   = 4'h6;
`ifdef MULDIV_ACC_EN
    localparam logic [3:0] OP_MADD  = 4'h7;
    localparam logic [3:0] OP_MADDU = 4'h8;
    localparam logic [3:0] OP_MSUB  = 4'h9;
    localparam logic [3:0] OP_MSUBU = 4'hA;
`endif
    localparam logic [2:0] LP_LAT   = 3'(MUL_LAT);

    // Ops that go through the multiplier path
    function automatic logic f_is_mul(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_MUL: f_is_mul = 1'b1;
`ifdef MULDIV_ACC_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: f_is_mul = 1'b1;
`endif
            default: f_is_mul = 1'b0;
        endcase
    endfunction

    // Signed flavours of the multiply path
    function automatic logic f_mul_signed(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MUL: f_mul_signed = 1'b1;
`ifdef MULDIV_ACC_EN
            OP_MADD, OP_MSUB: f_mul_signed = 1'b1;
`endif
            default: f_mul_signed = 1'b0;
        endcase
    endfunction

    state_t      r_state, w_next;
    logic [3:0]  r_op;
    logic [2:0]  r_cnt;
    logic [31:0] r_res_hi, r_res_lo, r_hi, r_lo;
    logic [3:0]  w_op;
    logic        w_accept, w_is_div, w_div0;
    logic [63:0] w_cap;

    // Latched op while pending keeps the signed controls stable after EXE moves on
    assign w_op     = (r_state == S_IDLE) ? bus.req_op : r_op;
    assign w_accept = (r_state == S_IDLE) && bus.req_valid && !bus.cancel;
    assign w_is_div = (bus.req_op == OP_DIV) || (bus.req_op == OP_DIVU);
    assign w_div0   = (bus.req_src2 == 32'd0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; cancel outranks every other event
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) begin
                if (f_is_mul(bus.req_op))     w_next = S_MUL_WAIT;
                else if (w_is_div && !w_div0) w_next = S_DIV_ISSUE;
                else                          w_next = S_DONE;
            end
            S_MUL_WAIT: begin
                if (bus.cancel)          w_next = S_IDLE;
                else if (r_cnt == 3'd1)  w_next = S_DONE;
            end
            S_DIV_ISSUE: begin
                // once the divider has taken operands its result must be drained
                if (bus.cancel)          w_next = bus.div_tready ? S_DRAIN : S_IDLE;
                else if (bus.div_tready) w_next = S_DIV_WAIT;
            end
            S_DIV_WAIT: begin
                if (bus.cancel)          w_next = bus.div_dout_tvalid ? S_IDLE : S_DRAIN;
                else if (bus.div_dout_tvalid) w_next = S_DONE;
            end
            S_DONE:  if (bus.cancel || bus.res_ack) w_next = S_IDLE;
            S_DRAIN: if (bus.div_dout_tvalid)      w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM-derived outputs
    always_comb begin
        bus.done       = (r_state == S_DONE);
        bus.busy       = (r_state != S_IDLE);
        bus.div_tvalid = (r_state == S_DIV_ISSUE);
        bus.mul_start  = w_accept && f_is_mul(bus.req_op);
        bus.mul_signed = f_mul_signed(w_op);
        bus.div_signed = (w_op == OP_DIV);
    end

    assign bus.mul_a  = bus.req_src1;
    assign bus.mul_b  = bus.req_src2;
    assign bus.res_hi = r_res_hi;
    assign bus.res_lo = r_res_lo;
    assign bus.hi     = r_hi;
    assign bus.lo     = r_lo;

    // Value captured at the end of the multiply wait (accumulate ops fold in HI/LO)
    always_comb begin
        w_cap = bus.mul_prod;
`ifdef MULDIV_ACC_EN
        case (r_op)
            OP_MADD, OP_MADDU: w_cap = {r_hi, r_lo} + bus.mul_prod;
            OP_MSUB, OP_MSUBU: w_cap = {r_hi, r_lo} - bus.mul_prod;
            default: ;
        endcase
`endif
    end

    // Datapath: op latch, latency counter, pending result and HI/LO commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= 4'd0;
            r_cnt    <= 3'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op <= bus.req_op;
                    if (f_is_mul(bus.req_op)) begin
                        r_cnt <= LP_LAT;
                    end else if (bus.req_op == OP_MTHI) begin
                        r_res_hi <= bus.req_src1;
                        r_res_lo <= r_lo;
                    end else if (bus.req_op == OP_MTLO) begin
                        r_res_hi <= r_hi;
                        r_res_lo <= bus.req_src1;
                    end else if (!(w_is_div && !w_div0)) begin
                        // divide-by-zero and illegal ops leave HI/LO as they are
                        r_res_hi <= r_hi;
                        r_res_lo <= r_lo;
                    end
                end
                S_MUL_WAIT: if (!bus.cancel) begin
                    if (r_cnt == 3'd1) {r_res_hi, r_res_lo} <= w_cap;
                    else               r_cnt <= r_cnt - 3'd1;
                end
                S_DIV_WAIT: if (!bus.cancel && bus.div_dout_tvalid) begin
                    r_res_lo <= bus.div_quot;
                    r_res_hi <= bus.div_rem;
                end
                S_DONE: if (!bus.cancel && bus.res_ack && r_op != OP_MUL) begin
                    r_hi <= r_res_hi;
                    r_lo <= r_res_lo;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed scoreboard bench for muldiv_ctrl with a fixed-latency
// multiplier model and a hand-driven divider.
module tb_muldiv_ctrl;
    localparam int MUL_LAT = 2;

    typedef struct {
        logic [31:0] rh, rl, ah, al;
    } exp_t;

    logic clk, reset;
    muldiv_ctrl_if u_if ();

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Multiplier model: product of the operands presented MUL_LAT cycles earlier
    logic [63:0] prod_pipe [MUL_LAT];
    logic [63:0] ea, eb;
    assign ea = u_if.mul_signed ? {{32{u_if.mul_a[31]}}, u_if.mul_a} : {32'd0, u_if.mul_a};
    assign eb = u_if.mul_signed ? {{32{u_if.mul_b[31]}}, u_if.mul_b} : {32'd0, u_if.mul_b};
    always @(posedge clk) begin
        prod_pipe[0] <= ea * eb;
        for (int i = 1; i < MUL_LAT; i++) prod_pipe[i] <= prod_pipe[i-1];
    end
    assign u_if.mul_prod = prod_pipe[MUL_LAT-1];

    // Monitor: on each acknowledged result pop the scoreboard, then check HI/LO a cycle later
    logic        chk_arch = 1'b0;
    exp_t        pend;
    always @(negedge clk) begin
        if (chk_arch) begin
            chk("arch hi", {32'd0, u_if.hi}, {32'd0, pend.ah});
            chk("arch lo", {32'd0, u_if.lo}, {32'd0, pend.al});
            chk_arch = 1'b0;
        end
        if (!reset && u_if.done && u_if.res_ack && !u_if.cancel) begin
            if (q.size() == 0) begin
                chk("unexpected result", 64'd1, 64'd0);
            end else begin
                pend = q.pop_front();
                chk("res_hi", {32'd0, u_if.res_hi}, {32'd0, pend.rh});
                chk("res_lo", {32'd0, u_if.res_lo}, {32'd0, pend.rl});
                chk_arch = 1'b1;
            end
        end
    end

    // Present a request for one cycle; checks mul_start in the accept cycle
    task automatic accept(input string nm, input logic [3:0] op, input logic [31:0] s1,
                          input logic [31:0] s2, input logic st);
        @(posedge clk); #1;
        u_if.req_valid = 1'b1; u_if.req_op = op; u_if.req_src1 = s1; u_if.req_src2 = s2;
        @(negedge clk);
        chk({nm, " mul_start"}, {63'd0, u_if.mul_start}, {63'd0, st});
        @(posedge clk); #1;
        u_if.req_valid = 1'b0;
    endtask

    // Counts clock edges after the accept edge until done is seen (bounded)
    task automatic wait_done(output int n);
        n = 0;
        while (!u_if.done && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic ack();
        u_if.res_ack = 1'b1;
        @(posedge clk); #1;
        u_if.res_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_op(input string nm, input logic [3:0] op, input logic [31:0] s1,
                         input logic [31:0] s2, input logic st, input int lat,
                         input logic [31:0] rh, input logic [31:0] rl,
                         input logic [31:0] ah, input logic [31:0] al);
        int n;
        q.push_back('{rh, rl, ah, al});
        accept(nm, op, s1, s2, st);
        wait_done(n);
        chk({nm, " latency"}, 64'(n), 64'(lat));
        ack();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        u_if.req_valid = 0; u_if.req_op = 0; u_if.req_src1 = 0; u_if.req_src2 = 0;
        u_if.cancel = 0; u_if.res_ack = 0; u_if.div_tready = 0;
        u_if.div_dout_tvalid = 0; u_if.div_quot = 0; u_if.div_rem = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst done", {63'd0, u_if.done}, 64'd0);
        chk("rst busy", {63'd0, u_if.busy}, 64'd0);
        chk("rst tvalid", {63'd0, u_if.div_tvalid}, 64'd0);
        chk("rst hilo", {u_if.hi, u_if.lo}, 64'd0);
        chk("rst res", {u_if.res_hi, u_if.res_lo}, 64'd0);
        reset = 1'b0;

        // multiplies (edges after accept before done == MUL_LAT)
        do_op("mult",  4'h0, 32'hFFFF_FFFE, 32'd3, 1'b1, 2,
              32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        do_op("multu", 4'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 2,
              32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0001);
        // moves, divide by zero, GPR-only MUL, illegal op
        do_op("mthi",  4'h4, 32'h11, 32'd0, 1'b0, 0, 32'h11, 32'h1, 32'h11, 32'h1);
        do_op("mtlo",  4'h5, 32'h22, 32'd0, 1'b0, 0, 32'h11, 32'h22, 32'h11, 32'h22);
        do_op("div0",  4'h2, 32'd5, 32'd0, 1'b0, 0, 32'h11, 32'h22, 32'h11, 32'h22);
        do_op("mul",   4'h6, 32'd7, 32'd6, 1'b1, 2, 32'h0, 32'd42, 32'h11, 32'h22);
        do_op("illegal", 4'hF, 32'd1, 32'd1, 1'b0, 0, 32'h11, 32'h22, 32'h11, 32'h22);

        // DIVU 100/7 with late tready and a slow result
        q.push_back('{32'd2, 32'd14, 32'd2, 32'd14});
        accept("divu", 4'h3, 32'd100, 32'd7, 1'b0);
        chk("divu tvalid", {63'd0, u_if.div_tvalid}, 64'd1);
        chk("divu signed", {63'd0, u_if.div_signed}, 64'd0);
        repeat (3) @(posedge clk);
        #1 u_if.div_tready = 1'b1;
        @(posedge clk); #1 u_if.div_tready = 1'b0;
        chk("divu tvalid drop", {63'd0, u_if.div_tvalid}, 64'd0);
        repeat (9) @(posedge clk);
        #1 u_if.div_dout_tvalid = 1'b1; u_if.div_quot = 32'd14; u_if.div_rem = 32'd2;
        @(posedge clk); #1 u_if.div_dout_tvalid = 1'b0;
        chk("divu done", {63'd0, u_if.done}, 64'd1);
        ack();

        // cancel in DIV_WAIT: drain, discard quotient, ignore requests meanwhile
        accept("div drain", 4'h2, 32'd50, 32'd5, 1'b0);
        chk("div signed", {63'd0, u_if.div_signed}, 64'd1);
        u_if.div_tready = 1'b1;
        @(posedge clk); #1 u_if.div_tready = 1'b0; u_if.cancel = 1'b1;
        @(posedge clk); #1 u_if.cancel = 1'b0;
        u_if.req_valid = 1'b1; u_if.req_op = 4'h4; u_if.req_src1 = 32'h77;
        repeat (3) @(posedge clk);
        #1;
        chk("drain busy", {63'd0, u_if.busy}, 64'd1);
        chk("drain done", {63'd0, u_if.done}, 64'd0);
        u_if.req_valid = 1'b0;
        u_if.div_dout_tvalid = 1'b1; u_if.div_quot = 32'd10; u_if.div_rem = 32'd0;
        @(posedge clk); #1 u_if.div_dout_tvalid = 1'b0;
        chk("drain exit busy", {63'd0, u_if.busy}, 64'd0);
        chk("drain hilo", {u_if.hi, u_if.lo}, {32'd2, 32'd14});
        do_op("mthi5", 4'h4, 32'h5, 32'd0, 1'b0, 0, 32'h5, 32'd14, 32'h5, 32'd14);

        // ack and cancel together in DONE: no commit
        begin
            int n;
            accept("mtlo cancel", 4'h5, 32'h99, 32'd0, 1'b0);
            wait_done(n);
            chk("mtlo cancel latency", 64'(n), 64'd0);
            u_if.res_ack = 1'b1; u_if.cancel = 1'b1;
            @(posedge clk); #1 u_if.res_ack = 1'b0; u_if.cancel = 1'b0;
            chk("ackcancel busy", {63'd0, u_if.busy}, 64'd0);
            chk("ackcancel hilo", {u_if.hi, u_if.lo}, {32'h5, 32'd14});
        end

        // cancel in DIV_ISSUE before tready
        accept("divu issue cancel", 4'h3, 32'd9, 32'd3, 1'b0);
        u_if.cancel = 1'b1;
        @(posedge clk); #1 u_if.cancel = 1'b0;
        chk("issue cancel busy", {63'd0, u_if.busy}, 64'd0);
        chk("issue cancel tvalid", {63'd0, u_if.div_tvalid}, 64'd0);

        // cancel coinciding with the divider result: straight to IDLE
        accept("divu wait cancel", 4'h3, 32'd9, 32'd3, 1'b0);
        u_if.div_tready = 1'b1;
        @(posedge clk); #1 u_if.div_tready = 1'b0;
        u_if.cancel = 1'b1; u_if.div_dout_tvalid = 1'b1; u_if.div_quot = 32'd3;
        @(posedge clk); #1 u_if.cancel = 1'b0; u_if.div_dout_tvalid = 1'b0;
        chk("wait cancel busy", {63'd0, u_if.busy}, 64'd0);
        chk("wait cancel hilo", {u_if.hi, u_if.lo}, {32'h5, 32'd14});

        // cancel during the multiply wait
        accept("mult cancel", 4'h0, 32'd3, 32'd3, 1'b1);
        u_if.cancel = 1'b1;
        @(posedge clk); #1 u_if.cancel = 1'b0;
        chk("mul cancel busy", {63'd0, u_if.busy}, 64'd0);
        repeat (3) @(posedge clk);
        #1 chk("mul cancel hilo", {u_if.hi, u_if.lo}, {32'h5, 32'd14});

        // accumulate encoding: MADDU 1*1 onto hi=0, lo=0xFFFFFFFF
        do_op("mthi0", 4'h4, 32'h0, 32'd0, 1'b0, 0, 32'h0, 32'd14, 32'h0, 32'd14);
        do_op("mtlo1s", 4'h5, 32'hFFFF_FFFF, 32'd0, 1'b0, 0,
              32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF);
`ifdef MULDIV_ACC_EN
        do_op("maddu", 4'h8, 32'd1, 32'd1, 1'b1, 2, 32'h1, 32'h0, 32'h1, 32'h0);
`else
        do_op("maddu", 4'h8, 32'd1, 32'd1, 1'b0, 0,
              32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF);
`endif

        repeat (2) @(posedge clk);
        chk("scoreboard empty", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
